multi_timer: RTL
================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter TIME_W, default 17, width of each channel's time value in seconds.
REQ-003 SHALL have parameter N_CH, default 2, number of independent countdown channels.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port load  input  N_CH  per-channel load strobe; captures start_time slice.
REQ-007 SHALL have port start_time  input  N_CH*TIME_W  per-channel start value; channel i at bits [i*TIME_W +: TIME_W].
REQ-008 SHALL have port run  input  N_CH  per-channel level; 1 = count, 0 = pause.
REQ-009 SHALL have port ack  input  N_CH  per-channel strobe; clears done/flash.
REQ-010 SHALL have port remaining  output  N_CH*TIME_W  per-channel seconds left, same packing as start_time.
REQ-011 SHALL have port done  output  N_CH  per-channel expiry flag.
REQ-012 SHALL have port flash  output  N_CH  per-channel display-flash level.
REQ-013 SHALL have port tick  output  1  one-cycle strobe, once per second.

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 free-running, wrap to 0; tick=1 exactly in the cycle the count equals CLK_HZ-1.
REQ-015 Each channel SHALL run FSM IDLE/RUN/PAUSE/DONE, plus registered remaining, shadow start value, done, flash.
REQ-016 load=1 in any state SHALL, next cycle: remaining and shadow = start_time slice, done=0, flash=0, state=IDLE.
REQ-017 IDLE: run=1 and remaining!=0 -> RUN; remaining==0 stays IDLE regardless of run.
REQ-018 RUN: tick decrements remaining by 1; run=0 -> PAUSE without decrement, even if tick coincides.
REQ-019 PAUSE: remaining held, ticks ignored; run=1 -> RUN.
REQ-020 RUN with tick and remaining==1 SHALL, next cycle: remaining=0, done=1, state=DONE.
REQ-021 DONE: remaining held at 0; flash toggles on every tick; ack=1 -> IDLE, done=0, flash=0 next cycle.
REQ-022 Priority per channel SHALL be load > ack > tick/run.
REQ-023 remaining SHALL never wrap below 0 nor exceed the loaded value.
REQ-024 First decrement SHALL occur 1..CLK_HZ cycles after entering RUN; prescaler is not restarted by run or load.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels all take effect in the same cycle.

Reset
REQ-026 reset=0 at a rising edge SHALL set prescaler=0, tick=0, and all channels state=IDLE, remaining=0, shadow=0, done=0, flash=0.
REQ-027 reset SHALL override load, ack, run and tick in the same cycle, including mid-countdown.

Configuration
REQ-028 Macro MULTI_TIMER_AUTORELOAD_EN SHALL select the expiry behaviour.
REQ-029 Without MULTI_TIMER_AUTORELOAD_EN, expiry SHALL behave per REQ-020/021.
REQ-030 With MULTI_TIMER_AUTORELOAD_EN, expiry SHALL set remaining=shadow and stay in RUN; done SHALL pulse 1 for one cycle; flash SHALL stay 0; DONE is never entered.

Structure
REQ-031 Package multi_timer_pkg SHALL hold the channel state enum and the default CLK_HZ and TIME_W constants.
REQ-032 Sub-module timer_prescaler SHALL implement REQ-014.
REQ-033 Channels SHALL be a generate loop of identical logic in multi_timer.
REQ-034 Prescaler width SHALL be $clog2(CLK_HZ), minimum 1.

Verification (CLK_HZ=4, TIME_W=17, N_CH=2)
REQ-035 Reset held 3 cycles while load/run are active -> all outputs 0; tick first seen 4 cycles after release.
REQ-036 ch0: load 3 then run=1 -> remaining 3,2,1,0 on successive ticks; done=1 the cycle after the 3rd tick; flash toggles every later tick; ack -> done=0, flash=0.
REQ-037 ch1: load 5, run 1 tick, run=0 for 3 ticks, then run=1 -> remaining sequence 5,4 (hold 3 ticks), then 3; ch0 unaffected.
REQ-038 load 0 with run=1 -> stays IDLE, remaining 0, done stays 0; load asserted during DONE together with ack -> reload wins, remaining = new value.
REQ-039 load 86399 -> remaining 86398 after first tick; reset mid-count -> remaining 0 next cycle.
REQ-040 MULTI_TIMER_AUTORELOAD_EN defined, load 2, run=1 -> remaining 2,1,2,1...; one-cycle done pulse per expiry; flash stays 0.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared types and defaults for the multi-channel countdown timer.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

    localparam int DEFAULT_CLK_HZ = 50000000;
    localparam int DEFAULT_TIME_W = 17;

    // Counter width for a 0..hz-1 prescaler; never narrower than one bit.
    function automatic int presc_width(input int hz);
        return (hz > 1) ? $clog2(hz) : 1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 0..CLK_HZ-1 counter producing a one-cycle tick while the count sits at CLK_HZ-1.
module timer_prescaler
    import multi_timer_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W = presc_width(CLK_HZ);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered from the next count so it is high exactly while cnt_q == LAST.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_timer.sv
// N_CH independent seconds countdown channels sharing one prescaler.
// Define MULTI_TIMER_AUTORELOAD_EN to reload from the shadow value on expiry instead of stopping.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int TIME_W = DEFAULT_TIME_W,
    parameter int N_CH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        load,
    input  logic [N_CH*TIME_W-1:0] start_time,
    input  logic [N_CH-1:0]        run,
    input  logic [N_CH-1:0]        ack,
    output logic [N_CH*TIME_W-1:0] remaining,
    output logic [N_CH-1:0]        done,
    output logic [N_CH-1:0]        flash,
    output logic                   tick
);

    logic tick_w;

    timer_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_w)
    );

    assign tick = tick_w;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            ch_state_e         state_q, state_d;
            logic [TIME_W-1:0] rem_q, rem_d;
            logic [TIME_W-1:0] shadow_q, shadow_d;
            logic [TIME_W-1:0] start_val;
            logic              done_q, done_d;
            logic              flash_q, flash_d;

            assign start_val = start_time[gi*TIME_W +: TIME_W];

            always_comb begin
                state_d  = state_q;
                rem_d    = rem_q;
                shadow_d = shadow_q;
                flash_d  = flash_q;
`ifdef MULTI_TIMER_AUTORELOAD_EN
                done_d   = 1'b0;
`else
                done_d   = done_q;
`endif
                if (load[gi]) begin
                    rem_d    = start_val;
                    shadow_d = start_val;
                    done_d   = 1'b0;
                    flash_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else if (ack[gi] && state_q == ST_DONE) begin
                    done_d  = 1'b0;
                    flash_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (run[gi] && rem_q != '0)
                                state_d = ST_RUN;
                        end
                        ST_RUN: begin
                            // Dropping run wins over a coincident tick.
                            if (!run[gi]) begin
                                state_d = ST_PAUSE;
                            end else if (tick_w) begin
                                if (rem_q == TIME_W'(1)) begin
`ifdef MULTI_TIMER_AUTORELOAD_EN
                                    rem_d   = shadow_q;
                                    done_d  = 1'b1;
`else
                                    rem_d   = '0;
                                    done_d  = 1'b1;
                                    state_d = ST_DONE;
`endif
                                end else if (rem_q != '0) begin
                                    rem_d = rem_q - 1'b1;
                                end
                            end
                        end
                        ST_PAUSE: begin
                            if (run[gi])
                                state_d = ST_RUN;
                        end
                        ST_DONE: begin
                            if (tick_w)
                                flash_d = ~flash_q;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    state_q  <= ST_IDLE;
                    rem_q    <= '0;
                    shadow_q <= '0;
                    done_q   <= 1'b0;
                    flash_q  <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    rem_q    <= rem_d;
                    shadow_q <= shadow_d;
                    done_q   <= done_d;
                    flash_q  <= flash_d;
                end
            end

            assign remaining[gi*TIME_W +: TIME_W] = rem_q;
            assign done[gi]                       = done_q;
            assign flash[gi]                      = flash_q;
        end
    endgenerate

endmodule
